// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator dispatcher and its request latch.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_e;

  localparam int N_FLOORS_DEFAULT = 3;
  localparam int FW_DEFAULT       = 2;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

endpackage

// File: rtl/elevator_req_latch.sv
// Pending-request register: inverts active-low buttons, accumulates presses,
// clears the floor being served and ignores presses for it while the door cycles.
module elevator_req_latch
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = N_FLOORS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] fb_n_i,
  input  logic [N_FLOORS-1:0] call_n_i,
  input  logic [N_FLOORS-1:0] cur_sel_i,
  input  logic                clear_i,
  input  logic                door_active_i,
  output logic [N_FLOORS-1:0] pending_o
);

  logic [N_FLOORS-1:0] pending_q;
  logic [N_FLOORS-1:0] pending_d;
  logic [N_FLOORS-1:0] press;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    press = ~fb_n_i | ~call_n_i;
    if (door_active_i) begin
      press = press & ~cur_sel_i;
    end
    pending_d = pending_q | press;
    // Clearing wins over a same-edge press: the door is about to serve that floor anyway.
    if (clear_i) begin
      pending_d = pending_d & ~cur_sel_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/elevator_dispatcher.sv
// SCAN collective-control dispatcher: picks the next door cycle or floor step
// and sequences the car over the step and door req/done handshakes.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = N_FLOORS_DEFAULT,
  parameter int FW       = FW_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] FB,
  input  logic [N_FLOORS-1:0] CALL,
  input  logic                step_done,
  input  logic                door_done,
  output logic                step_req,
  output logic                UD,
  output logic                door_req,
  output logic [FW-1:0]       cur_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [FW-1:0]       cur_floor_q, cur_floor_d;
  logic                ud_q, ud_d;

  logic [N_FLOORS-1:0] cur_sel;
  logic [N_FLOORS-1:0] above_sel;
  logic [N_FLOORS-1:0] below_sel;
  logic                here, ahead, behind;
  logic                clear_here;

  always_comb begin
    cur_sel   = '0;
    above_sel = '0;
    below_sel = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      cur_sel[i]   = (cur_floor_q == FW'(i + 1));
      above_sel[i] = (FW'(i + 1) > cur_floor_q);
      below_sel[i] = (FW'(i + 1) < cur_floor_q);
    end
  end

  assign here   = |(pending & cur_sel);
  assign ahead  = (ud_q == UP) ? |(pending & above_sel) : |(pending & below_sel);
  assign behind = (ud_q == UP) ? |(pending & below_sel) : |(pending & above_sel);

  assign clear_here = (state_q == IDLE) && here;

  elevator_req_latch #(
    .N_FLOORS(N_FLOORS)
  ) u_req_latch (
    .clk          (clk),
    .reset        (reset),
    .fb_n_i       (FB),
    .call_n_i     (CALL),
    .cur_sel_i    (cur_sel),
    .clear_i      (clear_here),
    .door_active_i(state_q == DOOR),
    .pending_o    (pending)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_floor_q <= FW'(1);
      ud_q        <= UP;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      ud_q        <= ud_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    ud_d        = ud_q;
    unique case (state_q)
      IDLE: begin
        if (here) begin
          state_d = DOOR;
        end else if (ahead) begin
          state_d = MOVE;
        end else if (behind) begin
          ud_d    = ~ud_q;
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (step_done) begin
          state_d = IDLE;
          // The end-floor guards only matter if a step were ever issued past the shaft ends.
          if (ud_q == UP && cur_floor_q != FW'(N_FLOORS)) begin
            cur_floor_d = cur_floor_q + FW'(1);
          end else if (ud_q == DOWN && cur_floor_q != FW'(1)) begin
            cur_floor_d = cur_floor_q - FW'(1);
          end
        end
      end
      DOOR: begin
        if (door_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    step_req  = (state_q == MOVE);
    door_req  = (state_q == DOOR);
    busy      = (state_q != IDLE);
    UD        = ud_q;
    cur_floor = cur_floor_q;
  end

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed scenario bench for elevator_dispatcher with hand-computed expectations.
module tb_elevator_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] FB, CALL;
  logic       step_done, door_done;
  logic       step_req, UD, door_req, busy;
  logic [1:0] cur_floor;
  logic [2:0] pending;

  int passed = 0;
  int total  = 0;
  int door_rises = 0;
  logic door_prev = 1'b0;

  elevator_dispatcher #(.N_FLOORS(3), .FW(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .FB       (FB),
    .CALL     (CALL),
    .step_done(step_done),
    .door_done(door_done),
    .step_req (step_req),
    .UD       (UD),
    .door_req (door_req),
    .cur_floor(cur_floor),
    .pending  (pending),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (door_req && !door_prev) door_rises++;
    door_prev = door_req;
  end

  // One rising edge, then settle 1 time unit past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; FB = 3'b111; CALL = 3'b111; step_done = 1'b0; door_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (cur_floor !== 2'd1) $display("FAIL reset_cur_floor cyc%0d: got %0d want 1", c, cur_floor); else passed++;
      total++; if ({step_req, door_req, busy, UD} !== 4'b0001) $display("FAIL reset_ctrl cyc%0d: got step/door/busy/UD=%b want 0001", c, {step_req, door_req, busy, UD}); else passed++;
      total++; if (pending !== 3'b000) $display("FAIL reset_pending cyc%0d: got %b want 000", c, pending); else passed++;
    end
  endtask

  task automatic test_single_call();
    CALL = 3'b101; tick(); CALL = 3'b111;
    total++; if (pending !== 3'b010) $display("FAIL call_latch: got %b want 010", pending); else passed++;
    total++; if (step_req !== 1'b0) $display("FAIL call_no_early_step: got %b want 0", step_req); else passed++;
    tick();
    total++; if ({step_req, UD, busy} !== 3'b111) $display("FAIL call_step: got step/UD/busy=%b want 111", {step_req, UD, busy}); else passed++;
    step_done = 1'b1; tick(); step_done = 1'b0;
    total++; if (cur_floor !== 2'd2) $display("FAIL call_floor: got %0d want 2", cur_floor); else passed++;
    total++; if (step_req !== 1'b0) $display("FAIL call_step_drop: got %b want 0", step_req); else passed++;
    tick();
    total++; if (door_req !== 1'b1) $display("FAIL call_door: got %b want 1", door_req); else passed++;
    total++; if (pending !== 3'b000) $display("FAIL call_clear: got %b want 000", pending); else passed++;
    door_done = 1'b1; tick(); door_done = 1'b0;
    total++; if ({door_req, busy} !== 2'b00) $display("FAIL call_door_done: got door/busy=%b want 00", {door_req, busy}); else passed++;
  endtask

  task automatic test_reversal();
    FB = 3'b110; tick(); FB = 3'b111;
    total++; if ({pending, UD, step_req} !== 5'b001_1_0) $display("FAIL rev_latch: got pend/UD/step=%b want 00110", {pending, UD, step_req}); else passed++;
    tick();
    total++; if ({UD, step_req} !== 2'b01) $display("FAIL rev_flip: got UD/step=%b want 01", {UD, step_req}); else passed++;
    step_done = 1'b1; tick(); step_done = 1'b0;
    total++; if (cur_floor !== 2'd1) $display("FAIL rev_floor: got %0d want 1", cur_floor); else passed++;
    tick();
    total++; if ({door_req, pending} !== 4'b1_000) $display("FAIL rev_door: got door/pend=%b want 1000", {door_req, pending}); else passed++;
    door_done = 1'b1; tick(); door_done = 1'b0;
  endtask

  task automatic test_collective_stop();
    FB = 3'b011; tick(); FB = 3'b111;
    total++; if (pending !== 3'b100) $display("FAIL coll_latch: got %b want 100", pending); else passed++;
    tick();
    total++; if ({step_req, UD} !== 2'b11) $display("FAIL coll_step1: got step/UD=%b want 11", {step_req, UD}); else passed++;
    CALL = 3'b101; tick(); CALL = 3'b111;
    total++; if ({pending, step_req} !== 4'b110_1) $display("FAIL coll_midstep: got pend/step=%b want 1101", {pending, step_req}); else passed++;
    step_done = 1'b1; tick(); step_done = 1'b0;
    total++; if (cur_floor !== 2'd2) $display("FAIL coll_floor2: got %0d want 2", cur_floor); else passed++;
    tick();
    total++; if ({door_req, pending} !== 4'b1_100) $display("FAIL coll_door2: got door/pend=%b want 1100", {door_req, pending}); else passed++;
    door_done = 1'b1; tick(); door_done = 1'b0;
    tick();
    total++; if ({step_req, UD, door_req} !== 3'b110) $display("FAIL coll_step2: got step/UD/door=%b want 110", {step_req, UD, door_req}); else passed++;
    step_done = 1'b1; tick(); step_done = 1'b0;
    total++; if (cur_floor !== 2'd3) $display("FAIL coll_floor3: got %0d want 3", cur_floor); else passed++;
    tick();
    total++; if ({door_req, pending} !== 4'b1_000) $display("FAIL coll_door3: got door/pend=%b want 1000", {door_req, pending}); else passed++;
    door_done = 1'b1; tick(); door_done = 1'b0;
    tick();
    // At the top floor with nothing pending the car must not step further up.
    total++; if ({step_req, busy, cur_floor} !== 4'b00_11) $display("FAIL coll_top_idle: got step/busy/floor=%b want 0011", {step_req, busy, cur_floor}); else passed++;
  endtask

  task automatic test_same_floor_mask();
    int rises_before;
    FB = 3'b101; tick(); FB = 3'b111;
    tick();
    total++; if ({step_req, UD} !== 2'b10) $display("FAIL mask_step_down: got step/UD=%b want 10", {step_req, UD}); else passed++;
    step_done = 1'b1; tick(); step_done = 1'b0;
    rises_before = door_rises;
    tick();
    total++; if ({door_req, cur_floor, pending} !== 6'b1_10_000) $display("FAIL mask_door: got door/floor/pend=%b want 110000", {door_req, cur_floor, pending}); else passed++;
    FB = 3'b101; tick(); tick(); FB = 3'b111;
    total++; if (pending !== 3'b000) $display("FAIL mask_pending: got %b want 000", pending); else passed++;
    door_done = 1'b1; tick(); door_done = 1'b0;
    tick(); tick(); tick();
    total++; if ({door_req, busy, pending} !== 5'b00_000) $display("FAIL mask_idle: got door/busy/pend=%b want 00000", {door_req, busy, pending}); else passed++;
    total++; if (door_rises - rises_before !== 1) $display("FAIL mask_door_count: got %0d want 1", door_rises - rises_before); else passed++;
  endtask

  task automatic test_reset_mid_step();
    FB = 3'b011; tick(); FB = 3'b111;
    tick();
    total++; if ({step_req, pending} !== 4'b1_100) $display("FAIL rst_pre: got step/pend=%b want 1100", {step_req, pending}); else passed++;
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if ({step_req, pending, cur_floor, UD, busy} !== 8'b0_000_01_1_0) $display("FAIL rst_mid: got step/pend/floor/UD/busy=%b want 00000110", {step_req, pending, cur_floor, UD, busy}); else passed++;
    step_done = 1'b1; tick(); step_done = 1'b0;
    total++; if ({cur_floor, step_req, busy} !== 4'b01_00) $display("FAIL rst_late_step_done: got floor/step/busy=%b want 0100", {cur_floor, step_req, busy}); else passed++;
    door_done = 1'b1; tick(); door_done = 1'b0;
    total++; if ({door_req, busy} !== 2'b00) $display("FAIL stray_door_done: got door/busy=%b want 00", {door_req, busy}); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_reversal();
    test_collective_stop();
    test_same_floor_mask();
    test_reset_mid_step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
